control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have clr, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ir_out, input, 32, the instruction register contents from datapath; fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
REQ-004 SHALL have mem_ready, input, 1, memory completed the current read or write this cycle.
REQ-005 SHALL have mem_read and mem_write, output, 1 each, memory request strobes.
REQ-006 SHALL have ir_en, pc_increment, pc_in_alu, pc_in_rf_a, ma_in_pc, ma_in_alu, md_in_memory, md_in_rf_b, alu_a_in_rf, alu_a_in_pc, alu_b_in_rf, alu_b_in_constant, lo_en, hi_en, rf_in_alu, rf_in_hi, rf_in_lo and rf_in_md, output, 1 each, datapath control strobes, all default 0.
REQ-007 SHALL have rf_a_addr, rf_b_addr and rf_z_addr, output, 4 each, register file addresses.
REQ-008 SHALL have alu_select, output, 12, one-hot: bit0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shra, 6 shl, 7 ror, 8 rol, 9 mul, 10 div, 11 neg/not; default 0.
REQ-009 SHALL have halted, output, 1, high while in HALT; illegal_op, output, 1, one-cycle pulse on an undefined opcode.

Function
REQ-010 SHALL be a Moore FSM with states RESET, F0, F1, F2, DEC, EXA, MEMW, WB, HALT; all outputs decode from state plus latched ir_out only.
REQ-011 RESET SHALL go to F0 the next cycle.
REQ-012 F0 SHALL assert ma_in_pc, then go to F1.
REQ-013 F1 SHALL hold mem_read high until mem_ready is high.
REQ-014 In the cycle mem_ready is high, F1 SHALL assert md_in_memory, then go to F2.
REQ-015 F2 SHALL assert ir_en and pc_increment for one cycle, then go to DEC.
REQ-016 DEC SHALL go to EXA for every opcode except three: halt (11011) goes to HALT; nop (11010) and any undefined opcode go to F0, an undefined opcode also pulsing illegal_op.
REQ-017 R-type opcodes are add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, neg 10001 and not 10010. In EXA they SHALL assert alu_a_in_rf, alu_b_in_rf, rf_in_alu and the matching alu_select bit, with rf_a_addr=rb, rf_b_addr=rc and rf_z_addr=ra, then go to F0.
REQ-018 neg and not SHALL both use alu_select bit 11, with ir_out[0] distinguishing them: 0 = neg, 1 = not.
REQ-019 addi (01100) SHALL behave as R-type add except alu_b_in_constant replaces alu_b_in_rf.
REQ-020 mul (01111) and div (10000) SHALL assert alu_select bit 9 or 10 with lo_en and hi_en in EXA, then go to F0.
REQ-021 mfhi (11000) and mflo (11001) SHALL assert rf_in_hi or rf_in_lo respectively, with rf_z_addr=ra, in EXA.
REQ-022 jr (10100) SHALL assert pc_in_rf_a with rf_a_addr=ra in EXA.
REQ-023 ld (00000) in EXA SHALL assert alu_a_in_rf, alu_b_in_constant, alu_select add and ma_in_alu with rf_a_addr=rb, then go to MEMW.
REQ-024 For ld, MEMW SHALL hold mem_read until mem_ready; in the mem_ready cycle it SHALL assert md_in_memory, then go to WB.
REQ-025 For ld, WB SHALL assert rf_in_md with rf_z_addr=ra, then go to F0.
REQ-026 st (00010) in EXA SHALL perform the same address computation as ld, plus md_in_rf_b with rf_b_addr=ra.
REQ-027 For st, MEMW SHALL hold mem_write until mem_ready, then go to F0; WB is not visited.
REQ-028 mem_read and mem_write SHALL never be high in the same cycle; exactly one transfer SHALL complete per request.
REQ-029 HALT SHALL be absorbing until clr and SHALL assert halted; all strobes are 0.
REQ-030 Instruction latency in cycles SHALL be: ALU/imm/mul/div/mf/jr 5; nop 4; ld 7 and st 6, each with zero-wait memory; every wait cycle adds 1.

Reset
REQ-031 clr high SHALL force state RESET immediately, regardless of clk.
REQ-032 During and after reset, all outputs SHALL be 0, including halted.
REQ-033 clr asserted mid-transfer SHALL drop mem_read and mem_write at once; a mem_ready arriving afterward SHALL be ignored.
REQ-034 Fetch SHALL restart from the datapath's current PC.

Verification
REQ-035 Bench SHALL cover add: ir=0x18900000 (add r1,r2,r0) with mem_ready always high -> rf_in_alu high with alu_select=0x001 and rf_z_addr=1, rf_a_addr=2, rf_b_addr=0 exactly in cycle 5 after F0 entry.
REQ-036 Bench SHALL cover a ld wait state: ld r3,0(r4) with mem_ready held low 3 cycles in MEMW -> mem_read high for 4 cycles, then rf_in_md with rf_z_addr=3 one cycle later; total 10 cycles.
REQ-037 Bench SHALL cover st: st r5 -> md_in_rf_b with rf_b_addr=5 in EXA, mem_write until mem_ready, WB never entered, mem_read low throughout.
REQ-038 Bench SHALL cover mul and mfhi: mul r6,r7 followed by mfhi r8 -> lo_en and hi_en with alu_select=0x200 in one cycle; later rf_in_hi with rf_z_addr=8.
REQ-039 Bench SHALL cover illegal and halt: opcode 11111 -> illegal_op pulses 1 cycle, then F0; then halt -> halted stays 1 for 20 cycles with all strobes 0.
REQ-040 Bench SHALL cover async reset: clr pulsed between clock edges during F1 -> mem_read falls before the next edge; after release, the first F0 asserts ma_in_pc.

Source files
------------

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Multi-cycle instruction sequencer for the datapath. Fetches an instruction
//   (F0..F2), decodes its opcode (DEC), executes (EXA) and, for ld/st, performs
//   the data memory transfer (MEMW) and register write-back (WB).
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   clr            : asynchronous active-high reset
//   ir_out[31:0]   : instruction register from the datapath
//                    opcode [31:27], ra [26:23], rb [22:19], rc [18:15]
//   mem_ready      : memory finishes the current read/write this cycle
//   mem_read/write : memory request strobes
//   ir_en .. rf_in_md : datapath control strobes
//   rf_a/b/z_addr  : register file addresses
//   alu_select     : one-hot ALU operation
//   halted         : high while in HALT
//   illegal_op     : one-cycle pulse when DEC sees an undefined opcode
// ---------------------------------------------------------------------------
module control_unit (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir_out,
   input  logic        mem_ready,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_en,
   output logic        pc_increment,
   output logic        pc_in_alu,
   output logic        pc_in_rf_a,
   output logic        ma_in_pc,
   output logic        ma_in_alu,
   output logic        md_in_memory,
   output logic        md_in_rf_b,
   output logic        alu_a_in_rf,
   output logic        alu_a_in_pc,
   output logic        alu_b_in_rf,
   output logic        alu_b_in_constant,
   output logic        lo_en,
   output logic        hi_en,
   output logic        rf_in_alu,
   output logic        rf_in_hi,
   output logic        rf_in_lo,
   output logic        rf_in_md,
   output logic [3:0]  rf_a_addr,
   output logic [3:0]  rf_b_addr,
   output logic [3:0]  rf_z_addr,
   output logic [11:0] alu_select,
   output logic        halted,
   output logic        illegal_op
);

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_F0    = 4'd1,
      S_F1    = 4'd2,
      S_F2    = 4'd3,
      S_DEC   = 4'd4,
      S_EXA   = 4'd5,
      S_MEMW  = 4'd6,
      S_WB    = 4'd7,
      S_HALT  = 4'd8
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // Registered control word; md_in_memory and illegal_op are handled
   // separately because they must react within the same cycle.
   typedef struct packed {
      logic        mem_read;
      logic        mem_write;
      logic        ir_en;
      logic        pc_increment;
      logic        pc_in_alu;
      logic        pc_in_rf_a;
      logic        ma_in_pc;
      logic        ma_in_alu;
      logic        md_in_rf_b;
      logic        alu_a_in_rf;
      logic        alu_a_in_pc;
      logic        alu_b_in_rf;
      logic        alu_b_in_constant;
      logic        lo_en;
      logic        hi_en;
      logic        rf_in_alu;
      logic        rf_in_hi;
      logic        rf_in_lo;
      logic        rf_in_md;
      logic        halted;
      logic [3:0]  rf_a_addr;
      logic [3:0]  rf_b_addr;
      logic [3:0]  rf_z_addr;
      logic [11:0] alu_select;
   } ctrl_t;

   // ir fields kept: [16:12] opcode, [11:8] ra, [7:4] rb, [3:0] rc
   state_t      state_q, state_d;
   logic [16:0] ir_q, ir_d;
   ctrl_t       ctrl_q;
   logic        ir_unused_s;

   // Low instruction bits carry immediates for the datapath only.
   assign ir_unused_s = ^ir_out[14:0];

   function automatic logic is_defined(input logic [4:0] op);
      logic ok;
      case (op)
         OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
         OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_MUL, OP_DIV, OP_NEG, OP_NOT,
         OP_JR, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT: ok = 1'b1;
         default:                                   ok = 1'b0;
      endcase
      return ok;
   endfunction

   // One-hot ALU select for the two-register / immediate ALU opcodes.
   function automatic logic [11:0] alu_onehot(input logic [4:0] op);
      logic [11:0] sel;
      case (op)
         OP_ADD, OP_ADDI: sel = 12'h001;
         OP_SUB:          sel = 12'h002;
         OP_AND:          sel = 12'h004;
         OP_OR:           sel = 12'h008;
         OP_SHR:          sel = 12'h010;
         OP_SHRA:         sel = 12'h020;
         OP_SHL:          sel = 12'h040;
         OP_ROR:          sel = 12'h080;
         OP_ROL:          sel = 12'h100;
         OP_NEG, OP_NOT:  sel = 12'h800;
         default:         sel = 12'h000;
      endcase
      return sel;
   endfunction

   // Moore decode of the control word for a given state and latched IR.
   function automatic ctrl_t decode_ctrl(input state_t st, input logic [16:0] ir);
      ctrl_t       c;
      logic [4:0]  op;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [3:0]  rc;
      c  = '0;
      op = ir[16:12];
      ra = ir[11:8];
      rb = ir[7:4];
      rc = ir[3:0];
      case (st)
         S_F0: c.ma_in_pc = 1'b1;
         S_F1: c.mem_read = 1'b1;
         S_F2: begin
            c.ir_en        = 1'b1;
            c.pc_increment = 1'b1;
         end
         S_EXA: begin
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
               OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_ADDI: begin
                  c.alu_a_in_rf       = 1'b1;
                  c.alu_b_in_rf       = (op != OP_ADDI);
                  c.alu_b_in_constant = (op == OP_ADDI);
                  c.rf_in_alu         = 1'b1;
                  c.alu_select        = alu_onehot(op);
                  c.rf_a_addr         = rb;
                  c.rf_b_addr         = rc;
                  c.rf_z_addr         = ra;
               end
               OP_MUL, OP_DIV: begin
                  c.alu_a_in_rf = 1'b1;
                  c.alu_b_in_rf = 1'b1;
                  c.rf_a_addr   = ra;
                  c.rf_b_addr   = rb;
                  c.alu_select  = (op == OP_MUL) ? 12'h200 : 12'h400;
                  c.lo_en       = 1'b1;
                  c.hi_en       = 1'b1;
               end
               OP_MFHI: begin
                  c.rf_in_hi  = 1'b1;
                  c.rf_z_addr = ra;
               end
               OP_MFLO: begin
                  c.rf_in_lo  = 1'b1;
                  c.rf_z_addr = ra;
               end
               OP_JR: begin
                  c.pc_in_rf_a = 1'b1;
                  c.rf_a_addr  = ra;
               end
               OP_LD, OP_ST: begin
                  // effective address = R[rb] + constant
                  c.alu_a_in_rf       = 1'b1;
                  c.alu_b_in_constant = 1'b1;
                  c.alu_select        = 12'h001;
                  c.ma_in_alu         = 1'b1;
                  c.rf_a_addr         = rb;
                  c.md_in_rf_b        = (op == OP_ST);
                  c.rf_b_addr         = (op == OP_ST) ? ra : 4'd0;
               end
               default: c = '0;
            endcase
         end
         S_MEMW: begin
            c.mem_read  = (op == OP_LD);
            c.mem_write = (op == OP_ST);
         end
         S_WB: begin
            c.rf_in_md  = 1'b1;
            c.rf_z_addr = ra;
         end
         S_HALT:  c.halted = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   // Next-state and IR latch logic.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_RESET: state_d = S_F0;
         S_F0:    state_d = S_F1;
         S_F1: begin
            if (mem_ready) begin
               state_d = S_F2;
            end else begin
               state_d = S_F1;
            end
         end
         S_F2:    state_d = S_DEC;
         S_DEC: begin
            ir_d = ir_out[31:15];
            if (ir_out[31:27] == OP_HALT) begin
               state_d = S_HALT;
            end else if ((ir_out[31:27] == OP_NOP) || !is_defined(ir_out[31:27])) begin
               state_d = S_F0;
            end else begin
               state_d = S_EXA;
            end
         end
         S_EXA: begin
            if ((ir_q[16:12] == OP_LD) || (ir_q[16:12] == OP_ST)) begin
               state_d = S_MEMW;
            end else begin
               state_d = S_F0;
            end
         end
         S_MEMW: begin
            if (!mem_ready) begin
               state_d = S_MEMW;
            end else if (ir_q[16:12] == OP_LD) begin
               state_d = S_WB;
            end else begin
               state_d = S_F0;
            end
         end
         S_WB:    state_d = S_F0;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

   // State, IR copy and control word registers; outputs are decoded from the
   // next state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= S_RESET;
         ir_q    <= 17'd0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ctrl_q  <= decode_ctrl(state_d, ir_d);
      end
   end

   // Memory data capture happens in the very cycle the transfer completes.
   assign md_in_memory = mem_ready &
                         ((state_q == S_F1) ||
                          ((state_q == S_MEMW) && (ir_q[16:12] == OP_LD)));

   // Flag the undefined opcode while DEC is looking at it.
   assign illegal_op = (state_q == S_DEC) && !is_defined(ir_out[31:27]);

   assign mem_read          = ctrl_q.mem_read;
   assign mem_write         = ctrl_q.mem_write;
   assign ir_en             = ctrl_q.ir_en;
   assign pc_increment      = ctrl_q.pc_increment;
   assign pc_in_alu         = ctrl_q.pc_in_alu;
   assign pc_in_rf_a        = ctrl_q.pc_in_rf_a;
   assign ma_in_pc          = ctrl_q.ma_in_pc;
   assign ma_in_alu         = ctrl_q.ma_in_alu;
   assign md_in_rf_b        = ctrl_q.md_in_rf_b;
   assign alu_a_in_rf       = ctrl_q.alu_a_in_rf;
   assign alu_a_in_pc       = ctrl_q.alu_a_in_pc;
   assign alu_b_in_rf       = ctrl_q.alu_b_in_rf;
   assign alu_b_in_constant = ctrl_q.alu_b_in_constant;
   assign lo_en             = ctrl_q.lo_en;
   assign hi_en             = ctrl_q.hi_en;
   assign rf_in_alu         = ctrl_q.rf_in_alu;
   assign rf_in_hi          = ctrl_q.rf_in_hi;
   assign rf_in_lo          = ctrl_q.rf_in_lo;
   assign rf_in_md          = ctrl_q.rf_in_md;
   assign rf_a_addr         = ctrl_q.rf_a_addr;
   assign rf_b_addr         = ctrl_q.rf_b_addr;
   assign rf_z_addr         = ctrl_q.rf_z_addr;
   assign alu_select        = ctrl_q.alu_select;
   assign halted            = ctrl_q.halted;

endmodule
